// File: rtl/noc_pkg.sv
// noc_pkg -- shared definitions for the PE <-> NoC switch interface.
//
// Holds the default mesh geometry, helpers that derive coordinate / payload
// field widths from the mesh size, and the TX / RX state encodings.
//
// Packet layout (MSB -> LSB): {dest_x, dest_y, data}
package noc_pkg;

  localparam int NOC_DEF_PACKET_SIZE = 16;
  localparam int NOC_DEF_XNO         = 4;
  localparam int NOC_DEF_YNO         = 4;

  // Width of one coordinate field; a one-column/row mesh still keeps a 1-bit field.
  function automatic int noc_coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the payload field once the address has been taken off the top.
  function automatic int noc_data_w(input int packet_size, input int xn, input int yn);
    return packet_size - noc_coord_w(xn) - noc_coord_w(yn);
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_SEND = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_POP  = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/pe_noc_iface.sv
// pe_noc_iface -- bridges a processing element to the local port of a mesh
// NoC switch.
//
// TX path: the PE hands over {dest, payload} with a valid/ready handshake; the
//   packet is registered, held until the switch PE FIFO reports room, then
//   written with a single-cycle strobe.
// RX path: a word showing at the head of the switch's first-word-fall-through
//   output FIFO is latched and popped with a single-cycle strobe. Words
//   addressed to this switch are presented to the PE until consumed; words
//   for any other address are dropped and flagged with rx_addr_err.
// The two paths share nothing but the clock and reset.
//
// Ports:
//   clk, i_reset                        clock, synchronous active-high reset
//   tx_valid/tx_ready                   PE -> interface handshake
//   tx_dest_x, tx_dest_y, tx_data       outgoing destination and payload
//   o_noc_data, o_noc_wr_valid          packet and write strobe to switch
//   i_noc_wr_ready                      switch PE input FIFO not full
//   i_noc_data, i_noc_rd_valid          head word of switch output FIFO
//   o_noc_rd_ready                      pop strobe to switch
//   rx_valid/rx_ready, rx_data          received payload to PE
//   rx_addr_err                         pulse when a misrouted word is dropped
//
// Build option: define PE_NOC_IFACE_STATS_EN to add saturating 16-bit
//   tx_count / rx_count / err_count outputs (sends, accepted receives,
//   dropped receives).
module pe_noc_iface
  import noc_pkg::*;
#(
  parameter int packet_size = NOC_DEF_PACKET_SIZE,
  parameter int x           = 0,
  parameter int y           = 0,
  parameter int xno_switch  = NOC_DEF_XNO,
  parameter int yno_switch  = NOC_DEF_YNO,
  localparam int XW = noc_coord_w(xno_switch),
  localparam int YW = noc_coord_w(yno_switch),
  localparam int AW = XW + YW,
  localparam int DW = noc_data_w(packet_size, xno_switch, yno_switch)
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [XW-1:0]          tx_dest_x,
  input  logic [YW-1:0]          tx_dest_y,
  input  logic [DW-1:0]          tx_data,
  output logic [packet_size-1:0] o_noc_data,
  output logic                   o_noc_wr_valid,
  input  logic                   i_noc_wr_ready,
  input  logic [packet_size-1:0] i_noc_data,
  input  logic                   i_noc_rd_valid,
  output logic                   o_noc_rd_ready,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [DW-1:0]          rx_data,
  output logic                   rx_addr_err
`ifdef PE_NOC_IFACE_STATS_EN
  ,
  output logic [15:0]            tx_count,
  output logic [15:0]            rx_count,
  output logic [15:0]            err_count
`endif
);

  localparam logic [XW-1:0] OWN_X    = XW'(x);
  localparam logic [YW-1:0] OWN_Y    = YW'(y);
  localparam logic [AW-1:0] OWN_ADDR = {OWN_X, OWN_Y};

  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;

  logic                   tx_load;
  logic                   rx_load;
  logic [packet_size-1:0] rx_pkt;
  logic                   addr_match;

  // ---- TX state register ----
  always_ff @(posedge clk) begin
    if (i_reset) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt   = tx_state;
    tx_ready       = 1'b0;
    o_noc_wr_valid = 1'b0;
    tx_load        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (i_noc_wr_ready) tx_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        // FIFO room was seen last cycle and only this interface writes the
        // PE port, so the strobe is safe without re-checking ready.
        o_noc_wr_valid = 1'b1;
        tx_state_nxt   = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---- TX packet register: held from accept until the strobe ----
  always_ff @(posedge clk) begin
    if (i_reset)      o_noc_data <= '0;
    else if (tx_load) o_noc_data <= {tx_dest_x, tx_dest_y, tx_data};
  end

  // ---- RX state register ----
  always_ff @(posedge clk) begin
    if (i_reset) rx_state <= RX_IDLE;
    else         rx_state <= rx_state_nxt;
  end

  assign addr_match = (rx_pkt[packet_size-1 -: AW] == OWN_ADDR);

  always_comb begin
    rx_state_nxt   = rx_state;
    o_noc_rd_ready = 1'b0;
    rx_valid       = 1'b0;
    rx_addr_err    = 1'b0;
    rx_load        = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (i_noc_rd_valid) begin
          rx_load      = 1'b1;
          rx_state_nxt = RX_POP;
        end
      end
      RX_POP: begin
        // The word is already latched, so the pop completes even if the
        // FIFO's valid has dropped in the meantime.
        o_noc_rd_ready = 1'b1;
        if (addr_match) begin
          rx_state_nxt = RX_HOLD;
        end else begin
          rx_addr_err  = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      RX_HOLD: begin
        rx_valid = 1'b1;
        if (rx_ready) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---- RX word register ----
  always_ff @(posedge clk) begin
    if (i_reset)      rx_pkt <= '0;
    else if (rx_load) rx_pkt <= i_noc_data;
  end

  assign rx_data = rx_pkt[DW-1:0];

`ifdef PE_NOC_IFACE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- statistics counters ----
  always_ff @(posedge clk) begin
    if (i_reset) begin
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      if (o_noc_wr_valid)                     tx_count  <= sat_inc(tx_count);
      if ((rx_state == RX_POP) && addr_match) rx_count  <= sat_inc(rx_count);
      if (rx_addr_err)                        err_count <= sat_inc(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_pe_noc_iface.sv
// Bench for pe_noc_iface with x=1, y=2 on a 4x4 mesh (16-bit packets,
// 2-bit coordinates, 12-bit payload). A transaction-level model predicts
// every output each cycle; directed sequences add hand-computed literals.
module tb_pe_noc_iface;

  localparam int PS = 16;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 12;
  localparam logic [3:0] OWN = 4'b0110;  // {x=1, y=2}

  logic          clk = 1'b0;
  logic          i_reset;
  logic          tx_valid;
  logic          tx_ready;
  logic [XW-1:0] tx_dest_x;
  logic [YW-1:0] tx_dest_y;
  logic [DW-1:0] tx_data;
  logic [PS-1:0] o_noc_data;
  logic          o_noc_wr_valid;
  logic          i_noc_wr_ready;
  logic [PS-1:0] i_noc_data;
  logic          i_noc_rd_valid;
  logic          o_noc_rd_ready;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_addr_err;
`ifdef PE_NOC_IFACE_STATS_EN
  logic [15:0]   tx_count, rx_count, err_count;
`endif

  always #5 clk = ~clk;

  pe_noc_iface #(
    .packet_size(16), .x(1), .y(2), .xno_switch(4), .yno_switch(4)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_data(tx_data),
    .o_noc_data(o_noc_data), .o_noc_wr_valid(o_noc_wr_valid),
    .i_noc_wr_ready(i_noc_wr_ready),
    .i_noc_data(i_noc_data), .i_noc_rd_valid(i_noc_rd_valid),
    .o_noc_rd_ready(o_noc_rd_ready),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_addr_err(rx_addr_err)
`ifdef PE_NOC_IFACE_STATS_EN
    ,
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // TX: a packet accepted while idle is written one cycle after the first
  //     cycle (following the accept) in which the switch reports room.
  // RX: a latched word is popped the next cycle; a good address is then
  //     offered until rx_ready, a bad one is dropped at the pop.
  bit            m_armed = 1'b0;
  bit            m_tx_busy;
  logic [PS-1:0] m_tx_pkt;
  int            m_tx_strobe;
  bit            m_rx_busy;
  logic [PS-1:0] m_rx_word;
  int            m_rx_lat;
  int            m_txc, m_rxc, m_errc;

  always @(posedge clk) begin
    if (i_reset) begin
      m_armed     <= 1'b1;
      m_tx_busy   <= 1'b0;
      m_tx_pkt    <= '0;
      m_tx_strobe <= -1;
      m_rx_busy   <= 1'b0;
      m_rx_word   <= '0;
      m_rx_lat    <= -10;
      m_txc       <= 0;
      m_rxc       <= 0;
      m_errc      <= 0;
    end else if (m_armed) begin
      if (!m_tx_busy) begin
        if (tx_valid) begin
          m_tx_busy   <= 1'b1;
          m_tx_pkt    <= {tx_dest_x, tx_dest_y, tx_data};
          m_tx_strobe <= -1;
        end
      end else if (m_tx_strobe == cyc) begin
        m_tx_busy <= 1'b0;
        m_txc     <= m_txc + 1;
      end else if (m_tx_strobe < 0 && i_noc_wr_ready) begin
        m_tx_strobe <= cyc + 1;
      end

      if (!m_rx_busy) begin
        if (i_noc_rd_valid) begin
          m_rx_busy <= 1'b1;
          m_rx_word <= i_noc_data;
          m_rx_lat  <= cyc;
        end
      end else if (cyc == m_rx_lat + 1) begin
        if (m_rx_word[15:12] != OWN) begin
          m_rx_busy <= 1'b0;
          m_errc    <= m_errc + 1;
        end else begin
          m_rxc <= m_rxc + 1;
        end
      end else if (rx_ready) begin
        m_rx_busy <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("tx_ready", 32'(tx_ready), 32'(!m_tx_busy));
      check("wr_valid", 32'(o_noc_wr_valid), 32'(m_tx_busy && m_tx_strobe == cyc));
      check("noc_data", 32'(o_noc_data), 32'(m_tx_pkt));
      check("rd_ready", 32'(o_noc_rd_ready), 32'(m_rx_busy && cyc == m_rx_lat + 1));
      check("addr_err", 32'(rx_addr_err),
            32'(m_rx_busy && cyc == m_rx_lat + 1 && m_rx_word[15:12] != OWN));
      check("rx_valid", 32'(rx_valid), 32'(m_rx_busy && cyc >= m_rx_lat + 2));
      check("rx_data", 32'(rx_data), 32'(m_rx_word[11:0]));
`ifdef PE_NOC_IFACE_STATS_EN
      check("tx_count", 32'(tx_count), 32'(m_txc));
      check("rx_count", 32'(rx_count), 32'(m_rxc));
      check("err_count", 32'(err_count), 32'(m_errc));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rxw [3];
    rxw[0] = 16'h6AAA;
    rxw[1] = 16'hF001;
    rxw[2] = 16'h6555;

    i_reset = 1'b1; tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_data = '0;
    i_noc_wr_ready = 1'b0; i_noc_data = '0; i_noc_rd_valid = 1'b0; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_wr_valid", 32'(o_noc_wr_valid), 32'd0);
    check("rst_rd_ready", 32'(o_noc_rd_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_addr_err", 32'(rx_addr_err), 32'd0);
    check("rst_noc_data", 32'(o_noc_data), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);

    // Send to (3,0) payload ABC with switch ready: strobe two cycles after accept
    step();
    i_noc_wr_ready = 1'b1;
    tx_valid = 1'b1; tx_dest_x = 2'd3; tx_dest_y = 2'd0; tx_data = 12'hABC;
    step();
    tx_valid = 1'b0;
    @(negedge clk);
    check("t1_busy", 32'(tx_ready), 32'd0);
    check("t1_no_early_strobe", 32'(o_noc_wr_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_strobe", 32'(o_noc_wr_valid), 32'd1);
    check("t1_data", 32'(o_noc_data), 32'h0000CABC);
    step();
    @(negedge clk);
    check("t1_strobe_end", 32'(o_noc_wr_valid), 32'd0);
    check("t1_ready_back", 32'(tx_ready), 32'd1);

    // Switch back-pressure for five cycles
    step();
    i_noc_wr_ready = 1'b0;
    tx_valid = 1'b1; tx_dest_x = 2'd1; tx_dest_y = 2'd1; tx_data = 12'h5A5;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_strobe", 32'(o_noc_wr_valid), 32'd0);
      check("t2_hold_ready", 32'(tx_ready), 32'd0);
      check("t2_hold_data", 32'(o_noc_data), 32'h000055A5);
      step();
    end
    i_noc_wr_ready = 1'b1;
    @(negedge clk);
    check("t2_wait_strobe", 32'(o_noc_wr_valid), 32'd0);
    step();
    @(negedge clk);
    check("t2_strobe", 32'(o_noc_wr_valid), 32'd1);
    step();
    @(negedge clk);
    check("t2_single_strobe", 32'(o_noc_wr_valid), 32'd0);

    // Good receive 6123; FIFO valid drops during the pop cycle
    step();
    i_noc_rd_valid = 1'b1; i_noc_data = 16'h6123;
    step();
    i_noc_rd_valid = 1'b0; i_noc_data = 16'hFFFF;
    @(negedge clk);
    check("t3_pop", 32'(o_noc_rd_ready), 32'd1);
    check("t3_not_yet_valid", 32'(rx_valid), 32'd0);
    step();
    @(negedge clk);
    check("t3_single_pop", 32'(o_noc_rd_ready), 32'd0);
    check("t3_valid", 32'(rx_valid), 32'd1);
    check("t3_data", 32'(rx_data), 32'h123);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("t3_hold_valid", 32'(rx_valid), 32'd1);
      check("t3_hold_data", 32'(rx_data), 32'h123);
    end
    step();
    rx_ready = 1'b1;
    @(negedge clk);
    check("t3_consume_valid", 32'(rx_valid), 32'd1);
    step();
    rx_ready = 1'b0;
    @(negedge clk);
    check("t3_released", 32'(rx_valid), 32'd0);

    // Misaddressed receive F001
    step();
    i_noc_rd_valid = 1'b1; i_noc_data = 16'hF001;
    step();
    i_noc_rd_valid = 1'b0;
    @(negedge clk);
    check("t4_pop", 32'(o_noc_rd_ready), 32'd1);
    check("t4_err", 32'(rx_addr_err), 32'd1);
    check("t4_no_valid", 32'(rx_valid), 32'd0);
    step();
    @(negedge clk);
    check("t4_err_pulse", 32'(rx_addr_err), 32'd0);
    check("t4_still_no_valid", 32'(rx_valid), 32'd0);

    // Reset with TX waiting and RX holding, both paths busy together
    step();
    i_noc_wr_ready = 1'b0;
    tx_valid = 1'b1; tx_dest_x = 2'd2; tx_dest_y = 2'd1; tx_data = 12'h3C3;
    i_noc_rd_valid = 1'b1; i_noc_data = 16'h6ABC;
    step();
    tx_valid = 1'b0; i_noc_rd_valid = 1'b0;
    step();
    @(negedge clk);
    check("t5_rx_holding", 32'(rx_valid), 32'd1);
    check("t5_tx_waiting", 32'(tx_ready), 32'd0);
    check("t5_tx_data", 32'(o_noc_data), 32'h000093C3);
    step();
    i_reset = 1'b1; i_noc_wr_ready = 1'b1;
    step();
    i_reset = 1'b0;
    @(negedge clk);
    check("t5_tx_ready", 32'(tx_ready), 32'd1);
    check("t5_wr_valid", 32'(o_noc_wr_valid), 32'd0);
    check("t5_rx_valid", 32'(rx_valid), 32'd0);
    check("t5_noc_data", 32'(o_noc_data), 32'd0);
    check("t5_rx_data", 32'(rx_data), 32'd0);
    step();
    @(negedge clk);
    check("t5_no_late_strobe", 32'(o_noc_wr_valid), 32'd0);

    // Three concurrent send/receive rounds: two good, one misaddressed word
    for (int i = 0; i < 3; i++) begin
      step();
      tx_valid = 1'b1; tx_dest_x = 2'(i); tx_dest_y = 2'(3 - i); tx_data = 12'(12'h111 * (i + 1));
      i_noc_rd_valid = 1'b1; i_noc_data = rxw[i]; rx_ready = 1'b1;
      step();
      tx_valid = 1'b0; i_noc_rd_valid = 1'b0;
      @(negedge clk);
      check("t6_pop", 32'(o_noc_rd_ready), 32'd1);
      step();
      @(negedge clk);
      check("t6_strobe", 32'(o_noc_wr_valid), 32'd1);
      check("t6_rx_valid", 32'(rx_valid), (i == 1) ? 32'd0 : 32'd1);
      step();
    end
    rx_ready = 1'b0;
    step();
    @(negedge clk);
`ifdef PE_NOC_IFACE_STATS_EN
    check("t6_tx_count", 32'(tx_count), 32'd3);
    check("t6_rx_count", 32'(rx_count), 32'd2);
    check("t6_err_count", 32'(err_count), 32'd1);
`endif
    check("t6_idle", 32'(tx_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_noc_iface.md
PE_NOC_IFACE -- requirements
Module: pe_noc_iface

Interface
REQ-001 SHALL have parameter packet_size, default 16, total packet width.
REQ-002 SHALL have parameter x, default 2'd0, own switch X coordinate.
REQ-003 SHALL have parameter y, default 2'd0, own switch Y coordinate.
REQ-004 SHALL have parameter xno_switch, default 4, mesh columns; addr X width = clog2(xno_switch).
REQ-005 SHALL have parameter yno_switch, default 4, mesh rows; addr Y width = clog2(yno_switch).
REQ-006 Ports SHALL be (AW = XW+YW; DW = packet_size-AW):
- clk  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  PE offers a packet.
- tx_ready  out  1  interface accepts the packet.
- tx_dest_x  in  XW  destination X.
- tx_dest_y  in  YW  destination Y.
- tx_data  in  DW  payload.
- o_noc_data  out  packet_size  to switch i_data_PE.
- o_noc_wr_valid  out  1  one-cycle write strobe to switch PE input FIFO.
- i_noc_wr_ready  in  1  switch o_wr_fifoReady_PE (not full).
- i_noc_data  in  packet_size  from switch o_data_PE, first-word-fall-through.
- i_noc_rd_valid  in  1  switch o_rd_valid_PE (not empty).
- o_noc_rd_ready  out  1  one-cycle pop strobe to switch i_rd_fifoReady_PE.
- rx_valid  out  1  received payload available.
- rx_ready  in  1  PE consumes payload.
- rx_data  out  DW  received payload.
- rx_addr_err  out  1  one-cycle pulse: received packet address is not {x,y}; packet dropped.

Function
REQ-007 Packet format SHALL be {dest_x, dest_y, data}; address in MSBs.
REQ-008 TX FSM SHALL have states TX_IDLE, TX_WAIT, TX_SEND; tx_ready = (state==TX_IDLE).
REQ-009 TX_IDLE: tx_valid&tx_ready SHALL register {tx_dest_x,tx_dest_y,tx_data} into o_noc_data, go TX_WAIT.
REQ-010 TX_WAIT: i_noc_wr_ready=1 SHALL go TX_SEND; otherwise stay, o_noc_data held stable.
REQ-011 TX_SEND: o_noc_wr_valid SHALL be 1 for exactly that cycle, then TX_IDLE; o_noc_wr_valid SHALL be 0 in all other states.
REQ-012 Accept at cycle N with switch ready SHALL give write strobe at N+2; max one packet per 3 cycles.
REQ-013 RX FSM SHALL have states RX_IDLE, RX_POP, RX_HOLD.
REQ-014 RX_IDLE: i_noc_rd_valid=1 SHALL latch i_noc_data into rx register and go RX_POP.
REQ-015 RX_POP: o_noc_rd_ready SHALL be 1 for exactly that cycle; address=={x,y} -> RX_HOLD, else rx_addr_err=1 that cycle and -> RX_IDLE.
REQ-016 RX_HOLD: rx_valid SHALL be 1, rx_data stable; rx_ready=1 -> RX_IDLE.
REQ-017 TX and RX paths SHALL be independent; simultaneous TX and RX activity SHALL not stall either.
REQ-018 Only one pop strobe per latched word; i_noc_rd_valid dropping in RX_POP SHALL still complete the pop.

Reset
REQ-019 i_reset SHALL force TX_IDLE, RX_IDLE; tx_ready=1 after release; o_noc_wr_valid, o_noc_rd_ready, rx_valid, rx_addr_err, o_noc_data, rx_data all 0.
REQ-020 Reset mid-transfer SHALL discard the in-flight packet with no strobe emitted.

Configuration
REQ-021 Macro PE_NOC_IFACE_STATS_EN defined: outputs tx_count, rx_count, err_count (each 16 bits, saturating at 16'hFFFF) SHALL count TX_SEND cycles, RX_HOLD entries, rx_addr_err pulses; cleared by reset.
REQ-022 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-023 Shared package noc_pkg SHALL hold address-width/field-position constants and TX/RX state enums.
REQ-024 No sub-module; both FSMs reside in pe_noc_iface.

Verification
REQ-025 x=1,y=2; tx dest (3,0) data 12'hABC, switch ready -> o_noc_data=16'hCABC, single strobe at N+2.
REQ-026 i_noc_wr_ready=0 for 5 cycles after accept -> no strobe, tx_ready=0, data stable; ready=1 -> exactly one strobe.
REQ-027 i_noc_data=16'h6123 valid (x=1,y=2) -> one pop strobe, rx_valid with rx_data=12'h123 held until rx_ready.
REQ-028 i_noc_data=16'hF001 -> one pop strobe, rx_addr_err pulse, rx_valid stays 0.
REQ-029 i_reset asserted in TX_WAIT and RX_HOLD -> no strobes, all outputs 0, tx_ready=1 next cycle.
REQ-030 STATS_EN: 3 sends, 2 good and 1 bad receive -> tx_count=3, rx_count=2, err_count=1.
